// File: rtl/dfp_addsub_seq.sv
// Digit-serial decimal floating-point add/subtract core.
// Aligns the smaller operand one BCD digit per cycle, then does one full-width BCD add/sub.
module dfp_addsub_seq #(
    parameter int              NDIG = 25,
    parameter int              EXPW = 12,
    parameter logic [EXPW-1:0] XINF = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  ld,
    input  logic [2:0]            rm,
    input  logic                  op,
    input  logic                  a_sign,
    input  logic                  b_sign,
    input  logic [EXPW-1:0]       a_exp,
    input  logic [EXPW-1:0]       b_exp,
    input  logic [NDIG*4-1:0]     a_sig,
    input  logic [NDIG*4-1:0]     b_sig,
    input  logic                  a_nan,
    input  logic                  b_nan,
    input  logic                  a_inf,
    input  logic                  b_inf,
    output logic                  busy,
    output logic                  done,
    output logic                  o_sign,
    output logic [EXPW-1:0]       o_exp,
    output logic [(NDIG+2)*4-1:0] o_sig,
    output logic                  o_sticky,
    output logic                  o_nan,
    output logic                  o_qnan,
    output logic                  o_inf
);
    localparam int              SW   = (NDIG+2)*4;
    localparam int              CW   = $clog2(NDIG+2);
    localparam logic [CW-1:0]   DMAX = CW'(NDIG+1);
    localparam logic [SW-1:0]   QSIG = {4'h0, 4'h9, {(NDIG-1){4'h0}}, 4'h0};

    typedef enum logic [2:0] {S_IDLE, S_CMP, S_ALIGN, S_ADD, S_DONE} state_t;
    state_t r_state, w_next;

    logic              r_op, r_as, r_bs, r_an, r_bn, r_ai, r_bi;
    logic [2:0]        r_rm;
    logic [EXPW-1:0]   r_ae, r_be, r_emax;
    logic [NDIG*4-1:0] r_asig, r_bsig;
    logic              r_realop, r_agtb, r_stk, r_zero;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_big, r_sml;
    logic              r_sign, r_sticky, r_nan, r_qnan, r_inf;
    logic [EXPW-1:0]   r_exp;
    logic [SW-1:0]     r_sig;

    logic              w_realop, w_agtb, w_special;
    logic [EXPW-1:0]   w_diff, w_emax;
    logic [CW-1:0]     w_d;
    logic [SW-1:0]     w_sum, w_dif;
    logic              w_c, w_bw;
    logic [4:0]        w_s, w_t;

    assign w_realop  = r_op ^ r_as ^ r_bs;
    assign w_agtb    = (r_ae > r_be) | ((r_ae == r_be) & (r_asig > r_bsig));
    assign w_diff    = (r_ae > r_be) ? (r_ae - r_be) : (r_be - r_ae);
    assign w_d       = (w_diff > EXPW'(NDIG+1)) ? DMAX : w_diff[CW-1:0];
    assign w_emax    = (r_ae > r_be) ? r_ae : r_be;
    assign w_special = r_an | r_bn | r_ai | r_bi;

    // Ripple BCD adder and subtractor over carry digit, NDIG digits and guard digit
    always_comb begin
        w_sum = '0;
        w_dif = '0;
        w_c   = 1'b0;
        w_bw  = 1'b0;
        w_s   = '0;
        w_t   = '0;
        for (int unsigned i = 0; i < NDIG+2; i++) begin
            w_s = {1'b0, r_big[i*4 +: 4]} + {1'b0, r_sml[i*4 +: 4]} + {4'b0, w_c};
            if (w_s > 5'd9) begin
                w_sum[i*4 +: 4] = 4'(w_s - 5'd10);
                w_c = 1'b1;
            end else begin
                w_sum[i*4 +: 4] = w_s[3:0];
                w_c = 1'b0;
            end
            w_t = {1'b0, r_big[i*4 +: 4]} - {1'b0, r_sml[i*4 +: 4]} - {4'b0, w_bw};
            if (w_t[4]) begin
                w_dif[i*4 +: 4] = 4'(w_t + 5'd10);
                w_bw = 1'b1;
            end else begin
                w_dif[i*4 +: 4] = w_t[3:0];
                w_bw = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else if (ce) r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ld) w_next = S_CMP;
            S_CMP:   w_next = w_special ? S_DONE : ((w_d == '0) ? S_ADD : S_ALIGN);
            S_ALIGN: if (r_cnt <= CW'(1)) w_next = S_ADD;
            S_ADD:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CMP) | (r_state == S_ALIGN) | (r_state == S_ADD);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_op, r_as, r_bs, r_an, r_bn, r_ai, r_bi} <= '0;
            r_rm <= '0; r_ae <= '0; r_be <= '0; r_asig <= '0; r_bsig <= '0;
            {r_realop, r_agtb, r_stk, r_zero} <= '0;
            r_cnt <= '0; r_big <= '0; r_sml <= '0; r_emax <= '0;
            {r_sign, r_sticky, r_nan, r_qnan, r_inf} <= '0;
            r_exp <= '0; r_sig <= '0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: if (ld) begin
                    r_op <= op; r_rm <= rm; r_as <= a_sign; r_bs <= b_sign;
                    r_ae <= a_exp; r_be <= b_exp; r_asig <= a_sig; r_bsig <= b_sig;
                    r_an <= a_nan; r_bn <= b_nan; r_ai <= a_inf; r_bi <= b_inf;
                end
                S_CMP: begin
                    r_realop <= w_realop;
                    r_agtb   <= w_agtb;
                    r_cnt    <= w_d;
                    r_stk    <= 1'b0;
                    r_emax   <= w_emax;
                    r_zero   <= (w_realop & (r_ae == r_be) & (r_asig == r_bsig)) |
                                ((r_asig == '0) & (r_bsig == '0));
                    r_big    <= w_agtb ? {4'h0, r_asig, 4'h0} : {4'h0, r_bsig, 4'h0};
                    r_sml    <= w_agtb ? {4'h0, r_bsig, 4'h0} : {4'h0, r_asig, 4'h0};
                    if (w_special) begin
                        r_exp    <= w_emax;
                        r_sticky <= 1'b0;
                        r_nan    <= 1'b0;
                        r_qnan   <= 1'b0;
                        r_inf    <= 1'b0;
                        r_sig    <= '0;
                        if (r_an | r_bn) begin
                            r_nan  <= 1'b1;
                            r_sig  <= {4'h0, (r_an ? r_asig : r_bsig), 4'h0};
                            r_sign <= r_an ? r_as : r_bs;
                        end else if (r_ai & r_bi) begin
                            r_qnan <= w_realop;
                            r_inf  <= ~w_realop;
                            r_sig  <= w_realop ? QSIG : '0;
                            r_sign <= r_as;
                        end else begin
                            r_inf  <= 1'b1;
                            r_sign <= r_ai ? r_as : (r_bs ^ r_op);
                        end
                    end
                end
                S_ALIGN: begin
                    r_sml <= r_sml >> 4;
                    r_stk <= r_stk | (r_sml[3:0] != 4'h0);
                    r_cnt <= r_cnt - CW'(1);
                end
                S_ADD: begin
                    r_nan  <= 1'b0;
                    r_qnan <= 1'b0;
                    if (r_zero) begin
                        r_sig    <= '0;
                        r_exp    <= '0;
                        r_sticky <= 1'b0;
                        r_sign   <= (r_rm == 3'd3);
                        r_inf    <= 1'b0;
                    end else begin
                        r_sig    <= r_realop ? w_dif : w_sum;
                        r_exp    <= r_emax;
                        r_sticky <= r_stk;
                        r_sign   <= r_realop ? (r_agtb ? r_as : (r_bs ^ r_op)) : r_as;
                        r_inf    <= (r_emax == XINF);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sign   = r_sign;
    assign o_exp    = r_exp;
    assign o_sig    = r_sig;
    assign o_sticky = r_sticky;
    assign o_nan    = r_nan;
    assign o_qnan   = r_qnan;
    assign o_inf    = r_inf;
endmodule
